// File: rtl/uart_counter_pkg.sv
// Definitions shared by the window edge counter and its stimulus twin, edge_pattern_gen:
// state encoding, count saturation and the default window length.
package uart_counter_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0]  MAX_COUNT             = 8'd250;
    localparam int unsigned DEFAULT_WINDOW_CYCLES = 12_500_000;
    localparam int unsigned DEFAULT_ACC_W         = 24;

    function automatic logic [7:0] clamp_count(input logic [7:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

endpackage

// File: rtl/edge_phase_acc.sv
// Phase accumulator. Adds `step` on each enabled cycle. Whenever the sum reaches the
// window length, it wraps by that length and raises `tick` for one cycle.
module edge_phase_acc
    import uart_counter_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned ACC_W         = DEFAULT_ACC_W
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] step,
    output logic       tick
);

    localparam logic [ACC_W-1:0] WINDOW = ACC_W'(WINDOW_CYCLES);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    // NOTE: combinational logic uses blocking '=' with a default for every output first, so no latch is inferred.
    always_comb begin
        sum   = acc_q + ACC_W'(step);
        tick  = enable && (sum >= WINDOW);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = tick ? (sum - WINDOW) : sum;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/edge_pattern_gen.sv
// Programmable toggle source. In each low phase of tim025 it emits the latched
// count (clamped to 250) of evenly spaced toggles on sig_out.
module edge_pattern_gen
    import uart_counter_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned ACC_W         = DEFAULT_ACC_W
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tim025,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       sig_out,
    output logic       busy,
    output logic [7:0] emitted,
    output logic       window_done,
    output logic       underrun
);

    state_e     state_q;
    logic [7:0] pending_q;
    logic [7:0] active_q;
    logic [7:0] emitted_q;
    logic       sig_q;
    logic       busy_q;
    logic       done_q;
    logic       under_q;

    logic [7:0] load_value;
    logic [7:0] active_d;
    logic [7:0] emitted_d;
    logic       acc_clear;
    logic       acc_enable;
    logic       tick;

    assign load_value = clamp_count(data_in);
    assign active_d   = load ? load_value : pending_q;
    assign emitted_d  = emitted_q + 8'd1;
    assign acc_clear  = (state_q == ST_WAIT) || (state_q == ST_LATCH);
    // The boundary outranks a coincident overflow, so the accumulator is gated by tim025.
    assign acc_enable = (state_q == ST_RUN) && !tim025;

    edge_phase_acc #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .ACC_W         (ACC_W)
    ) u_acc (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (acc_clear),
        .enable (acc_enable),
        .step   (active_q),
        .tick   (tick)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else if (load) begin
            pending_q <= load_value;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_WAIT;
            active_q  <= '0;
            emitted_q <= '0;
            sig_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            under_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    active_q  <= active_d;
                    emitted_q <= '0;
                    if (tim025) state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    active_q  <= active_d;
                    emitted_q <= '0;
                    if (!tim025) begin
                        if (active_d != '0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (tim025) begin
                        state_q <= ST_LATCH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        under_q <= (emitted_q < active_q);
                    end else if (tick) begin
                        sig_q     <= ~sig_q;
                        emitted_q <= emitted_d;
                        if (emitted_d == active_q) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (tim025) begin
                        state_q <= ST_LATCH;
                        done_q  <= 1'b1;
                        under_q <= (emitted_q < active_q);
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign sig_out     = sig_q;
    assign busy        = busy_q;
    assign emitted     = emitted_q;
    assign window_done = done_q;
    assign underrun    = under_q;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Bench for edge_pattern_gen with a 1000-cycle window. The model predicts the toggles
// due by RUN cycle k as floor(k*N/W), capped at N.
module tb_edge_pattern_gen;

    localparam int W = 1000;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b1;
    logic       tim025  = 1'b0;
    logic       load    = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       sig_out;
    logic       busy;
    logic [7:0] emitted;
    logic       window_done;
    logic       underrun;

    int checks   = 0;
    int failures = 0;
    int level_exp = 0;
    int pending_m = 0;

    edge_pattern_gen #(
        .WINDOW_CYCLES (W),
        .ACC_W         (24)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .tim025      (tim025),
        .data_in     (data_in),
        .load        (load),
        .sig_out     (sig_out),
        .busy        (busy),
        .emitted     (emitted),
        .window_done (window_done),
        .underrun    (underrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input int v);
        data_in = 8'(v);
        load    = 1'b1;
        step();
        load      = 1'b0;
        pending_m = (v > 250) ? 250 : v;
    endtask

    // Precondition: the DUT is in LATCH with tim025 high. The window stays open for
    // len RUN cycles. If bload >= 0, a load of bload is issued on the closing edge.
    task automatic run_window(input int len, input int bload);
        int n;
        int t;
        int t_end;
        int edges;
        int prev;
        n = pending_m;
        tim025 = 1'b0;
        step();
        check("entry_busy", busy, (n != 0) ? 1 : 0);
        check("entry_emitted", emitted, 0);
        prev  = sig_out;
        edges = 0;
        for (int k = 1; k <= len; k++) begin
            step();
            t = (k * n) / W;
            if (t > n) t = n;
            check("run_level", sig_out, level_exp ^ (t & 1));
            check("run_emitted", emitted, t);
            check("run_busy", busy, (t < n) ? 1 : 0);
            if (sig_out != prev) edges++;
            prev = sig_out;
        end
        t_end = (len * n) / W;
        if (t_end > n) t_end = n;
        tim025 = 1'b1;
        if (bload >= 0) begin
            data_in = 8'(bload);
            load    = 1'b1;
        end
        step();
        if (bload >= 0) begin
            load      = 1'b0;
            pending_m = (bload > 250) ? 250 : bload;
        end
        check("bnd_window_done", window_done, 1);
        check("bnd_underrun", underrun, (t_end < n) ? 1 : 0);
        check("bnd_emitted", emitted, t_end);
        check("bnd_level_no_toggle", sig_out, level_exp ^ (t_end & 1));
        check("bnd_busy", busy, 0);
        check("loopback_edges", edges, t_end);
        level_exp = level_exp ^ (t_end & 1);
        step();
        check("latch_window_done", window_done, 0);
        check("latch_underrun", underrun, 0);
        check("latch_emitted", emitted, 0);
    endtask

    initial begin
        #2 reset = 1'b0;
        step();
        step();
        check("rst_sig_out", sig_out, 0);
        check("rst_busy", busy, 0);
        check("rst_emitted", emitted, 0);
        check("rst_window_done", window_done, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b1;
        step();

        // Four toggles in a nominal window, after a 20-cycle boundary.
        tim025 = 1'b1;
        do_load(4);
        repeat (19) step();
        run_window(W, -1);

        // 255 clamps to 250, one toggle every 4 cycles.
        do_load(255);
        run_window(W, -1);

        // A zero count goes straight to DONE with no toggles.
        do_load(0);
        run_window(W, -1);

        // A short window ends in underrun.
        do_load(10);
        run_window(500, -1);
        // The closing edge lands on an overflow, and the boundary wins.
        do_load(10);
        run_window(599, -1);

        // A load on the closing edge replaces the pending count for the next window.
        do_load(3);
        run_window(W, 7);
        run_window(W, -1);

        // Random counts and window lengths.
        for (int r = 0; r < 4; r++) begin
            do_load(int'($urandom_range(0, 255)));
            run_window(int'($urandom_range(400, 1100)), -1);
        end

        // Reset asserted in the middle of RUN.
        do_load(9);
        tim025 = 1'b0;
        repeat (300) step();
        #2 reset = 1'b0;
        #1;
        check("midrun_rst_sig_out", sig_out, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_emitted", emitted, 0);
        check("midrun_rst_window_done", window_done, 0);
        check("midrun_rst_underrun", underrun, 0);
        step();
        step();
        reset     = 1'b1;
        level_exp = 0;
        pending_m = 0;
        tim025    = 1'b1;
        repeat (3) step();
        run_window(W, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_pattern_gen.md
# edge_pattern_gen

Stimulus-side twin of the window edge counter. It receives an 8-bit edge count and, in each gated measurement window, drives exactly that many evenly spaced toggles on `sig_out`. Its `tim025` window input has the same meaning as the counter's. It sits between the byte source (host/UART receive path) and the counter's `sig_in`, so it serves as a loopback self-test and as a programmable test-signal source.

## Interface
- `WINDOW_CYCLES`, 12_500_000: `clk_in` cycles in one low (active) phase of `tim025`; legal range 500 … 2^24−251.
- `ACC_W`, 24: phase-accumulator width; must hold `WINDOW_CYCLES + 250`.
- `clk_in` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tim025` input 1: 0 = window active (generate), 1 = window boundary (latch new count).
- `data_in` input 8: requested toggles per window.
- `load` input 1: one-cycle strobe; captures `data_in` into the pending register.
- `sig_out` output 1: generated signal; registered.
- `busy` output 1: high while in RUN.
- `emitted` output 8: toggles issued in the current window.
- `window_done` output 1: one-cycle pulse when leaving RUN/DONE into LATCH.
- `underrun` output 1: one-cycle pulse, coincident with `window_done`, when the window ended with `emitted < active`.

## Operation
- **Clamp.** Captured counts are clamped to `MAX_COUNT` = 250, matching the counter's saturation. `pending <= min(data_in, 250)` on `load`.
- **States.**
  - WAIT: after reset.
  - LATCH: `tim025` = 1.
  - RUN: generating.
  - DONE: all toggles issued, window still open.
- **Transitions.**
  - WAIT → LATCH when `tim025` = 1.
  - LATCH → RUN when `tim025` = 0 and `active` ≠ 0.
  - LATCH → DONE when `tim025` = 0 and `active` = 0.
  - RUN → DONE when a toggle makes `emitted == active`.
  - RUN → LATCH when `tim025` = 1 (short window; `underrun` pulses).
  - DONE → LATCH when `tim025` = 1.
- **In WAIT and LATCH, every cycle:**
  - `active <= load ? min(data_in, 250) : pending`. A `load` in the same cycle bypasses `pending`, so the last value before the window opens wins.
  - `acc <= 0`, `emitted <= 0`.
- **In RUN, every cycle:**
  - `s = acc + active`.
  - If `s ≥ WINDOW_CYCLES`: `acc <= s − WINDOW_CYCLES`, `sig_out <= ~sig_out`, `emitted <= emitted + 1`.
  - Otherwise: `acc <= s`.
- **Spacing.** Over a full window exactly `active` toggles occur, spaced ⌊W/N⌋ or ⌈W/N⌉ cycles apart. The minimum spacing is ≥ 2 cycles because W ≥ 500, which suffices for the counter's two-flop edge detector.
- **Levels and loads.**
  - The `sig_out` level is never forced at window boundaries; the counter counts both edges.
  - `load` is accepted in any state; it affects only the next LATCH.
- **Reset (asynchronous, any time, including mid-RUN):**
  - State → WAIT.
  - `sig_out`, `busy`, `window_done`, `underrun` = 0.
  - `emitted`, `pending`, `active`, `acc` = 0.

## Timing
- **Reset values:** every output is 0.
- **Load:** `load` to `pending` valid takes 1 cycle.
- **Window entry:** state becomes RUN the cycle after `tim025` is sampled low in LATCH.
- **Toggle position:** with RUN cycle 1 being the first RUN cycle, toggle i (1-based) appears on `sig_out` after the edge of RUN cycle ⌈i·W/N⌉.
- **Last toggle:** the last toggle lands on RUN cycle W exactly, i.e. just before a nominal-length window closes.
- **Boundary signalling:** `window_done` and `underrun` are registered and asserted in the first LATCH cycle.
- **Pending updates:**
  - `emitted` updates in the same cycle as `sig_out`.
  - `emitted` holds through DONE and clears in LATCH.
- **Simultaneous events:** if `tim025` rises in the same cycle as an overflow, the boundary wins and no toggle is issued.
- **No cross-window carry:** the accumulator is discarded at every boundary.

## Structure
- **Shared package `uart_counter_pkg`:**
  - State encoding: WAIT = 2'd0, LATCH = 2'd1, RUN = 2'd2, DONE = 2'd3.
  - `MAX_COUNT` = 8'd250, also used by the counter.
  - Default `WINDOW_CYCLES`.
- **One sub-module, `edge_phase_acc`:** accumulator, compare/subtract, and the overflow strobe. It takes `clear`, `enable` and `step[7:0]` and emits `tick`.
- **Top level:** FSM, clamp, pending/active registers, output flops.

## Test plan
All scenarios use `WINDOW_CYCLES` = 1000.

- `load` 4, `tim025` high 20 cycles then low 1000 → 4 toggles on RUN cycles 250/500/750/1000, DONE reached, `emitted` = 4, `window_done` = 1, `underrun` = 0 at next boundary.
- `load` 255 → `active` = 250, 250 toggles with spacing exactly 4 cycles, `emitted` = 250.
- `load` 0 → LATCH→DONE directly, `sig_out` constant, `busy` never high, `emitted` = 0.
- `load` 10, `tim025` returns high after 500 RUN cycles → 5 toggles, `underrun` pulses one cycle together with `window_done`, `emitted` resets in LATCH.
- `load` 7 in the same cycle `tim025` rises while old `pending` = 3 → next window emits 7. Then assert `reset` low mid-RUN → all outputs 0 immediately, state WAIT, next window emits 0 until reloaded.
- Loopback into the counter (`sig_out` → `sig_in`, shared `tim025`), `load` 100 → counter `data_out` = 100 after the boundary. Repeat with 250 → `data_out` = 250.
